// File: rtl/cprv_fetch_queue.sv
// cprv_fetch_queue: instruction fetch front end.
// Issues sequential imem requests under a credit scheme so every response is
// guaranteed a queue slot, buffers returned instructions in a circular FIFO
// for the ID stage, and discards stale responses after a redirect.
module cprv_fetch_queue #(
    parameter int unsigned               DATA_WIDTH = 64,
    parameter int unsigned               DEPTH      = 4,
    parameter int unsigned               MAX_OUTST  = 2,
    parameter logic [DATA_WIDTH-1:0]     RESET_PC   = '0
) (
    input  logic                         clk,
    input  logic                         rst,

    // redirect / flush
    input  logic                         redirect_i,
    input  logic [DATA_WIDTH-1:0]        redirect_pc_i,

    // imem request channel
    output logic                         valid_imem_o,
    input  logic                         ready_imem_i,
    output logic [DATA_WIDTH-1:0]        instr_addr_imem_o,

    // imem response channel
    input  logic                         valid_if_i,
    output logic                         ready_if_o,
    input  logic [DATA_WIDTH-1:0]        instr_data_imem_i,

    // ID stage channel
    output logic                         valid_id_o,
    input  logic                         ready_id_i,
    output logic [31:0]                  instr_data_id_o,
    output logic [DATA_WIDTH-1:0]        instr_pc_id_o,

    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    // ------------------------------------------------------------------
    // Local widths and constants
    // ------------------------------------------------------------------
    // CW holds 0..DEPTH; outst and dcnt never exceed DEPTH either.
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [CW-1:0]         DEPTH_C     = CW'(DEPTH);
    localparam logic [CW-1:0]         MAX_OUTST_C = CW'(MAX_OUTST);
    localparam logic [CW-1:0]         ONE_C       = CW'(1);
    localparam logic [PW-1:0]         PTR_ONE     = PW'(1);
    localparam logic [DATA_WIDTH-1:0] PC_STEP     = DATA_WIDTH'(4);

    typedef struct packed {
        logic [31:0]           instr;
        logic [DATA_WIDTH-1:0] pc;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] fpc_q,    fpc_d;     // next request address
    logic [DATA_WIDTH-1:0] rpc_q,    rpc_d;     // PC of next kept response
    logic [CW-1:0]         count_q,  count_d;   // queue occupancy
    logic [CW-1:0]         outst_q,  outst_d;   // requests in flight
    logic [CW-1:0]         dcnt_q,   dcnt_d;    // responses still to discard
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;

    entry_t                mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic [CW:0] credit_sum;
    logic        credit_ok;
    logic        req_fire;
    logic        resp_fire;
    logic        push;
    logic        pop;
    logic        queue_nonempty;
    entry_t      push_entry;
    entry_t      head_entry;

    assign credit_sum     = {1'b0, outst_q} + {1'b0, count_q};
    assign credit_ok      = (outst_q < MAX_OUTST_C) && (credit_sum < {1'b0, DEPTH_C});
    assign queue_nonempty = (count_q != '0);

    // The request is a pure function of registered state plus redirect, so
    // once raised it stays raised and stable until accepted: outst only grows
    // on accept, and a push is always paired with an outst decrement.
    // It is also forced low while reset is held.
    assign valid_imem_o      = credit_ok && !redirect_i && !rst;
    assign instr_addr_imem_o = fpc_q;

    // Credits reserve a slot for every outstanding request, so responses
    // can always be taken.
    assign ready_if_o = 1'b1;

    assign req_fire  = valid_imem_o && ready_imem_i;
    assign resp_fire = valid_if_i && ready_if_o;

    // A response is kept only when no flush is in progress and nothing
    // older still needs discarding.
    assign push = resp_fire && !redirect_i && (dcnt_q == '0);

    assign valid_id_o = queue_nonempty && !redirect_i;
    assign pop        = valid_id_o && ready_id_i;

    assign push_entry.instr = instr_data_imem_i[31:0];
    assign push_entry.pc    = rpc_q;

    // The head slot is never written while it is occupied (the queue cannot
    // be full when a response arrives), so the outputs hold under stall.
    // The empty case reads as zero so that reset shows clean outputs even
    // though the storage itself is not reset.
    assign head_entry      = mem_q[rd_ptr_q];
    assign instr_data_id_o = queue_nonempty ? head_entry.instr : 32'h0;
    assign instr_pc_id_o   = queue_nonempty ? head_entry.pc    : '0;

    assign level_o = count_q;

    // ------------------------------------------------------------------
    // Next-state logic for PCs, counters and pointers
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path can leave one
        // unassigned; a missing default in always_comb infers a latch.
        fpc_d    = fpc_q;
        rpc_d    = rpc_q;
        count_d  = count_q;
        outst_d  = outst_q;
        dcnt_d   = dcnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        // In-flight bookkeeping applies whether or not a redirect is active;
        // req_fire is already blocked during redirect.
        case ({req_fire, resp_fire})
            2'b10:   outst_d = outst_q + ONE_C;
            2'b01:   outst_d = outst_q - ONE_C;
            default: outst_d = outst_q;
        endcase

        if (redirect_i) begin
            // Flush: restart both PCs at the target, empty the queue and
            // discard everything still in flight after this cycle.
            fpc_d    = redirect_pc_i;
            rpc_d    = redirect_pc_i;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            dcnt_d   = outst_d;
        end else begin
            if (req_fire) begin
                fpc_d = fpc_q + PC_STEP;
            end

            if (resp_fire && (dcnt_q != '0)) begin
                dcnt_d = dcnt_q - ONE_C;
            end

            if (push) begin
                rpc_d    = rpc_q + PC_STEP;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            case ({push, pop})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q    <= RESET_PC;
            rpc_q    <= RESET_PC;
            count_q  <= '0;
            outst_q  <= '0;
            dcnt_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of order.
            fpc_q    <= fpc_d;
            rpc_q    <= rpc_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            dcnt_q   <= dcnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Queue storage write port.
    // NOTE: the storage array has no reset; occupancy and pointers decide
    // what is valid, and the read path masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: tb/tb_cprv_fetch_queue.sv
// Directed bench for cprv_fetch_queue: streaming, backpressure, redirects,
// address wrap and asynchronous reset, against a 1-cycle imem.
module tb_cprv_fetch_queue;

    localparam int unsigned DW = 64;

    logic          clk;
    logic          rst;
    logic          redirect_i;
    logic [DW-1:0] redirect_pc_i;
    logic          valid_imem_o;
    logic          ready_imem_i;
    logic [DW-1:0] instr_addr_imem_o;
    logic          valid_if_i;
    logic          ready_if_o;
    logic [DW-1:0] instr_data_imem_i;
    logic          valid_id_o;
    logic          ready_id_i;
    logic [31:0]   instr_data_id_o;
    logic [DW-1:0] instr_pc_id_o;
    logic [2:0]    level_o;

    cprv_fetch_queue #(
        .DATA_WIDTH (DW),
        .DEPTH      (4),
        .MAX_OUTST  (2),
        .RESET_PC   ('0)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .valid_imem_o      (valid_imem_o),
        .ready_imem_i      (ready_imem_i),
        .instr_addr_imem_o (instr_addr_imem_o),
        .valid_if_i        (valid_if_i),
        .ready_if_o        (ready_if_o),
        .instr_data_imem_i (instr_data_imem_i),
        .valid_id_o        (valid_id_o),
        .ready_id_i        (ready_id_i),
        .instr_data_id_o   (instr_data_id_o),
        .instr_pc_id_o     (instr_pc_id_o),
        .level_o           (level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // stimulus knobs
    logic          imem_rdy;
    logic          id_rdy;
    logic          resp_en;
    logic          redir;
    logic [DW-1:0] redir_pc;

    // values sampled mid-cycle
    logic          s_vimem;
    logic [DW-1:0] s_addr;
    logic          s_vid;
    logic [DW-1:0] s_pc;
    logic [31:0]   s_data;

    // imem model and transaction logs
    logic [DW-1:0] pend[$];
    logic [DW-1:0] req_log[$];
    logic [DW-1:0] pop_pc[$];
    logic [31:0]   pop_data[$];

    int base;

    // Instruction word stored at an address in the imem model.
    function automatic logic [31:0] data_of(logic [DW-1:0] a);
        return a[31:0] ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit later, log handshakes
    // at the rising edge.
    task automatic cycle();
        logic [DW-1:0] a;
        @(negedge clk);
        ready_imem_i  = imem_rdy;
        ready_id_i    = id_rdy;
        redirect_i    = redir;
        redirect_pc_i = redir_pc;
        if (resp_en && pend.size() > 0) begin
            a = pend.pop_front();
            valid_if_i        = 1'b1;
            instr_data_imem_i = {~a[63:32], data_of(a)};
        end else begin
            valid_if_i        = 1'b0;
            instr_data_imem_i = '0;
        end
        #1;
        s_vimem = valid_imem_o;
        s_addr  = instr_addr_imem_o;
        s_vid   = valid_id_o;
        s_pc    = instr_pc_id_o;
        s_data  = instr_data_id_o;
        @(posedge clk);
        if (s_vimem && imem_rdy) begin
            pend.push_back(s_addr);
            req_log.push_back(s_addr);
        end
        if (s_vid && id_rdy) begin
            pop_pc.push_back(s_pc);
            pop_data.push_back(s_data);
        end
    endtask

    task automatic clear_logs();
        pend.delete();
        req_log.delete();
        pop_pc.delete();
        pop_data.delete();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        valid_if_i = 1'b0;
        redirect_i = 1'b0;
        redir      = 1'b0;
        clear_logs();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        redirect_i        = 1'b0;
        redirect_pc_i     = '0;
        ready_imem_i      = 1'b0;
        valid_if_i        = 1'b0;
        instr_data_imem_i = '0;
        ready_id_i        = 1'b0;
        imem_rdy = 1'b1; id_rdy = 1'b1; resp_en = 1'b1;
        redir    = 1'b0; redir_pc = '0;

        // ---------------- reset state ----------------
        #3;
        check("rst_valid_imem", DW'(valid_imem_o), 64'd0);
        check("rst_valid_id",   DW'(valid_id_o),   64'd0);
        check("rst_level",      DW'(level_o),      64'd0);
        check("rst_instr_data", DW'(instr_data_id_o), 64'd0);
        check("rst_instr_pc",   instr_pc_id_o,     64'd0);
        check("rst_addr",       instr_addr_imem_o, 64'd0);
        check("rst_ready_if",   DW'(ready_if_o),   64'd1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // ---------------- streaming ----------------
        repeat (10) cycle();
        check("stream_nreq", DW'(req_log.size()), 64'd10);
        check("stream_npop", DW'(pop_pc.size()),  64'd8);
        for (int i = 0; i < 8; i++) begin
            check("stream_req_addr", req_log[i], DW'(4 * i));
            check("stream_pop_pc",   pop_pc[i],  DW'(4 * i));
            check("stream_pop_data", DW'(pop_data[i]), DW'(data_of(DW'(4 * i))));
        end

        // ---------------- backpressure ----------------
        do_reset();
        id_rdy = 1'b0;
        repeat (8) cycle();
        check("bp_nreq", DW'(req_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("bp_req_addr", req_log[i], DW'(4 * i));
        #1;
        check("bp_level_full",   DW'(level_o), 64'd4);
        check("bp_valid_imem",   DW'(s_vimem), 64'd0);
        check("bp_valid_id",     DW'(s_vid),   64'd1);
        check("bp_hold_pc",      s_pc,         64'd0);
        check("bp_hold_data",    DW'(s_data),  DW'(data_of(64'd0)));
        id_rdy = 1'b1;
        repeat (4) cycle();
        check("bp_npop", DW'(pop_pc.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("bp_pop_pc",   pop_pc[i], DW'(4 * i));
            check("bp_pop_data", DW'(pop_data[i]), DW'(data_of(DW'(4 * i))));
        end

        // ---------------- redirect with two in flight ----------------
        do_reset();
        resp_en = 1'b0;
        repeat (3) cycle();
        check("rd2_nreq", DW'(req_log.size()), 64'd2);
        check("rd2_credit_block", DW'(s_vimem), 64'd0);
        redir = 1'b1; redir_pc = 64'h100;
        cycle();
        check("rd2_vimem_in_redirect", DW'(s_vimem), 64'd0);
        redir = 1'b0; resp_en = 1'b1;
        #1;
        check("rd2_level_after", DW'(level_o), 64'd0);
        cycle();
        check("rd2_no_req_while_draining", DW'(req_log.size()), 64'd2);
        repeat (5) cycle();
        check("rd2_req_target", req_log[2], 64'h100);
        check("rd2_npop",       DW'(pop_pc.size()), 64'd3);
        check("rd2_first_pc",   pop_pc[0], 64'h100);
        check("rd2_first_data", DW'(pop_data[0]), DW'(data_of(64'h100)));
        check("rd2_second_pc",  pop_pc[1], 64'h104);

        // ---------------- redirect with response and pop ----------------
        do_reset();
        repeat (6) cycle();
        check("rdp_npop_before", DW'(pop_pc.size()), 64'd4);
        redir = 1'b1; redir_pc = 64'h100;
        cycle();
        check("rdp_valid_id",    DW'(s_vid),   64'd0);
        check("rdp_valid_imem",  DW'(s_vimem), 64'd0);
        check("rdp_no_pop",      DW'(pop_pc.size()), 64'd4);
        redir = 1'b0;
        #1;
        check("rdp_level_after", DW'(level_o), 64'd0);
        cycle();
        check("rdp_req_immediate", DW'(req_log.size()), 64'd7);
        check("rdp_req_addr",      req_log[6], 64'h100);
        repeat (3) cycle();
        check("rdp_pop_pc0",   pop_pc[4], 64'h100);
        check("rdp_pop_data0", DW'(pop_data[4]), DW'(data_of(64'h100)));
        check("rdp_pop_pc1",   pop_pc[5], 64'h104);

        // ---------------- back-to-back redirects and address wrap ----------------
        do_reset();
        repeat (3) cycle();
        redir = 1'b1; redir_pc = 64'h200;
        cycle();
        redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        redir = 1'b0;
        repeat (16) cycle();
        check("wrap_req0", req_log[3], 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_req1", req_log[4], 64'h0);
        check("wrap_npop", DW'(pop_pc.size()), 64'd15);
        base = 1;
        for (int i = 0; i < 11; i++) begin
            logic [DW-1:0] exp_pc;
            exp_pc = 64'hFFFF_FFFF_FFFF_FFFC + DW'(4 * i);
            check("wrap_pop_pc",   pop_pc[base + i], exp_pc);
            check("wrap_pop_data", DW'(pop_data[base + i]), DW'(data_of(exp_pc)));
        end

        // ---------------- async reset mid-stream ----------------
        #3;
        check("ar_level_before", DW'(level_o), 64'd1);
        rst = 1'b1;
        #1;
        check("ar_valid_imem",  DW'(valid_imem_o), 64'd0);
        check("ar_valid_id",    DW'(valid_id_o),   64'd0);
        check("ar_level",       DW'(level_o),      64'd0);
        check("ar_instr_data",  DW'(instr_data_id_o), 64'd0);
        check("ar_instr_pc",    instr_pc_id_o,     64'd0);
        check("ar_addr",        instr_addr_imem_o, 64'd0);
        valid_if_i = 1'b0;
        clear_logs();
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) cycle();
        check("ar_first_req", req_log[0], 64'd0);
        check("ar_first_pop", pop_pc[0],  64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
